// File: rtl/fma_arbiter_if.sv
// fma_arbiter_if: requester, response and shared-datapath signals of fma_arbiter.
interface fma_arbiter_if;
  logic req0_valid, req1_valid, req0_ready, req1_ready;
  logic [15:0] req0_a, req0_b, req0_c, req1_a, req1_b, req1_c;
  logic [15:0] fma_a, fma_b, fma_c, fma_result;
  logic rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [15:0] rsp_data, disp_value;
  logic busy;
  logic [7:0] done_count;
  modport slave (
    input req0_valid, req1_valid, req0_a, req0_b, req0_c, req1_a, req1_b, req1_c,
    input fma_result, rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready, fma_a, fma_b, fma_c,
    output rsp0_valid, rsp1_valid, rsp_data, busy, disp_value, done_count
  );
  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req0_c, req1_a, req1_b, req1_c,
    output fma_result, rsp0_ready, rsp1_ready,
    input req0_ready, req1_ready, fma_a, fma_b, fma_c,
    input rsp0_valid, rsp1_valid, rsp_data, busy, disp_value, done_count
  );
endinterface

// File: rtl/fma_arbiter.sv
// fma_arbiter: round-robin sharing of one combinational bf16 FMA datapath between two requesters.
module fma_arbiter #(
  parameter int LAT = 1
) (
  input logic clk,
  input logic reset,
  fma_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, nxt;
  logic owner, ptr, grant1, accept, consume;
  logic [3:0] cnt;
  // requester 1 wins when alone, or when both ask and it holds priority
  assign grant1 = bus.req1_valid & (~bus.req0_valid | ptr);
  assign accept = (state == IDLE) & (bus.req0_valid | bus.req1_valid);
  assign consume = (state == RESP) & (owner ? bus.rsp1_ready : bus.rsp0_ready);
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = accept ? WAIT : IDLE;
      WAIT: nxt = (cnt == 4'd1) ? RESP : WAIT;
      RESP: nxt = consume ? IDLE : RESP;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    bus.req0_ready = (state == IDLE) & bus.req0_valid & ~grant1;
    bus.req1_ready = (state == IDLE) & grant1;
    bus.rsp0_valid = (state == RESP) & ~owner;
    bus.rsp1_valid = (state == RESP) & owner;
    bus.busy = state != IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      owner <= 1'b0;
      ptr <= 1'b0;
      cnt <= 4'd0;
      bus.fma_a <= 16'd0;
      bus.fma_b <= 16'd0;
      bus.fma_c <= 16'd0;
      bus.rsp_data <= 16'd0;
      bus.disp_value <= 16'd0;
      bus.done_count <= 8'd0;
    end else begin
      if (accept) begin
        owner <= grant1;
        cnt <= 4'(LAT);
        bus.fma_a <= grant1 ? bus.req1_a : bus.req0_a;
        bus.fma_b <= grant1 ? bus.req1_b : bus.req0_b;
        bus.fma_c <= grant1 ? bus.req1_c : bus.req0_c;
      end
      if (state == WAIT) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) bus.rsp_data <= bus.fma_result;
      end
      if (consume) begin
        bus.disp_value <= bus.rsp_data;
        bus.done_count <= bus.done_count + 8'd1;
        ptr <= ~owner;
      end
    end
endmodule

// File: tb/tb_fma_arbiter.sv
// tb_fma_arbiter: directed, table-driven check of fma_arbiter with a bf16 multiply-then-add datapath model.
module tb_fma_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int passed = 0;
  int total = 0;
  int cnt_exp = 0;
  typedef struct {
    bit who;
    logic [15:0] a, b, c, r;
  } vec_t;
  vec_t vt[6];
  fma_arbiter_if ifc ();
  fma_arbiter_if ifc4 ();
  fma_arbiter #(.LAT(1)) u0 (.clk(clk), .reset(reset), .bus(ifc.slave));
  fma_arbiter #(.LAT(4)) u4 (.clk(clk), .reset(reset), .bus(ifc4.slave));
  always #5 clk = ~clk;
  function automatic real to_real(input logic [15:0] x);
    logic [63:0] d;
    if (x[14:7] == 8'd0) return 0.0;
    d = {x[15], 11'(x[14:7]) + 11'd896, x[6:0], 45'd0};
    return $bitstoreal(d);
  endfunction
  function automatic logic [15:0] to_bf16(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    e = d[62:52];
    if (e < 11'd897) return {d[63], 15'd0};
    return {d[63], 8'(e - 11'd896), d[51:45]};
  endfunction
  function automatic logic [15:0] bf16_fma(input logic [15:0] a, b, c);
    real p;
    p = to_real(to_bf16(to_real(a) * to_real(b)));
    return to_bf16(p + to_real(c));
  endfunction
  always_comb ifc.fma_result = bf16_fma(ifc.fma_a, ifc.fma_b, ifc.fma_c);
  always_comb ifc4.fma_result = bf16_fma(ifc4.fma_a, ifc4.fma_b, ifc4.fma_c);
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic run_op(input vec_t v);
    if (v.who) begin
      ifc.req1_valid = 1'b1; ifc.req1_a = v.a; ifc.req1_b = v.b; ifc.req1_c = v.c;
    end else begin
      ifc.req0_valid = 1'b1; ifc.req0_a = v.a; ifc.req0_b = v.b; ifc.req0_c = v.c;
    end
    #1;
    chk("grant_ready", v.who ? ifc.req1_ready : ifc.req0_ready, 1);
    chk("other_ready", v.who ? ifc.req0_ready : ifc.req1_ready, 0);
    @(negedge clk);
    ifc.req0_valid = 1'b0;
    ifc.req1_valid = 1'b0;
    chk("wait_busy", ifc.busy, 1);
    chk("wait_operands", {ifc.fma_a, ifc.fma_b}, {v.a, v.b});
    chk("wait_c", ifc.fma_c, v.c);
    chk("wait_rsp_low", {ifc.rsp1_valid, ifc.rsp0_valid}, 0);
    @(negedge clk);
    chk("rsp_valid", {ifc.rsp1_valid, ifc.rsp0_valid}, v.who ? 2'b10 : 2'b01);
    chk("rsp_data", ifc.rsp_data, v.r);
    @(negedge clk);
    cnt_exp++;
    chk("disp_value", ifc.disp_value, v.r);
    chk("done_count", ifc.done_count, 8'(cnt_exp));
    chk("idle_busy", ifc.busy, 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    bit found;
    vt[0] = '{1'b0, 16'h3F80, 16'h4000, 16'h3F80, 16'h4040};
    vt[1] = '{1'b1, 16'h4040, 16'h4000, 16'h3F80, 16'h40E0};
    vt[2] = '{1'b0, 16'h4000, 16'h4000, 16'h0000, 16'h4080};
    vt[3] = '{1'b1, 16'h3F00, 16'h4080, 16'hC000, 16'h0000};
    vt[4] = '{1'b0, 16'h4040, 16'h4040, 16'hBF80, 16'h4100};
    vt[5] = '{1'b1, 16'hC040, 16'h4000, 16'h0000, 16'hC0C0};
    {ifc.req0_valid, ifc.req1_valid, ifc.rsp0_ready, ifc.rsp1_ready} = 4'b0011;
    {ifc.req0_a, ifc.req0_b, ifc.req0_c, ifc.req1_a, ifc.req1_b, ifc.req1_c} = '0;
    {ifc4.req0_valid, ifc4.req1_valid, ifc4.rsp0_ready, ifc4.rsp1_ready} = 4'b0011;
    {ifc4.req0_a, ifc4.req0_b, ifc4.req0_c, ifc4.req1_a, ifc4.req1_b, ifc4.req1_c} = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {ifc.busy, ifc.rsp0_valid, ifc.rsp1_valid, ifc.req0_ready, ifc.req1_ready}, 0);
    chk("reset_regs", {ifc.fma_a, ifc.fma_b, ifc.fma_c, ifc.rsp_data}, 0);
    chk("reset_disp", {ifc.disp_value, ifc.done_count}, 0);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 6; i++) run_op(vt[i]);
    // both held valid: grants must alternate starting with requester 0
    ifc.req0_valid = 1'b1; ifc.req0_a = 16'h4000; ifc.req0_b = 16'h4000; ifc.req0_c = 16'h0000;
    ifc.req1_valid = 1'b1; ifc.req1_a = 16'h4040; ifc.req1_b = 16'h4000; ifc.req1_c = 16'h3F80;
    #1;
    chk("simul_first_grant", {ifc.req1_ready, ifc.req0_ready}, 2'b01);
    for (int k = 0; k < 4; k++) begin
      found = 1'b0;
      for (int t = 0; t < 8 && !found; t++) begin
        @(negedge clk);
        found = ifc.rsp0_valid | ifc.rsp1_valid;
      end
      chk("simul_rsp_seen", found, 1);
      chk("simul_owner", {ifc.rsp1_valid, ifc.rsp0_valid}, (k % 2) ? 2'b10 : 2'b01);
      chk("simul_data", ifc.rsp_data, (k % 2) ? 16'h40E0 : 16'h4080);
    end
    ifc.req0_valid = 1'b0;
    ifc.req1_valid = 1'b0;
    @(negedge clk);
    cnt_exp += 4;
    chk("simul_count", ifc.done_count, 8'(cnt_exp));
    // response backpressure with a competing request and stray rsp1_ready pulses
    ifc.rsp0_ready = 1'b0; ifc.rsp1_ready = 1'b0;
    ifc.req0_valid = 1'b1; ifc.req0_a = 16'h3F80; ifc.req0_b = 16'h4000; ifc.req0_c = 16'h3F80;
    @(negedge clk);
    ifc.req0_valid = 1'b0;
    ifc.req1_valid = 1'b1; ifc.req1_a = 16'h4000; ifc.req1_b = 16'h4000; ifc.req1_c = 16'h4000;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk("stall_rsp", {ifc.rsp1_valid, ifc.rsp0_valid, ifc.busy, ifc.req0_ready, ifc.req1_ready}, 5'b01100);
      chk("stall_data", ifc.rsp_data, 16'h4040);
      ifc.rsp1_ready = i[0];
      @(negedge clk);
    end
    ifc.rsp1_ready = 1'b0;
    ifc.req1_valid = 1'b0;
    ifc.rsp0_ready = 1'b1;
    @(negedge clk);
    cnt_exp++;
    chk("stall_release", {ifc.busy, ifc.rsp0_valid}, 0);
    chk("stall_count", ifc.done_count, 8'(cnt_exp));
    chk("stall_disp", ifc.disp_value, 16'h4040);
    ifc.rsp1_ready = 1'b1;
    // LAT=4 instance: response first visible in cycle 5 after acceptance
    ifc4.req0_valid = 1'b1; ifc4.req0_a = 16'h4040; ifc4.req0_b = 16'h4040; ifc4.req0_c = 16'hBF80;
    #1;
    chk("lat4_ready", ifc4.req0_ready, 1);
    @(negedge clk);
    ifc4.req0_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      chk("lat4_wait", {ifc4.busy, ifc4.rsp0_valid, ifc4.rsp1_valid}, 3'b100);
      chk("lat4_operands", {ifc4.fma_a, ifc4.fma_b, ifc4.fma_c}, {16'h4040, 16'h4040, 16'hBF80});
      @(negedge clk);
    end
    chk("lat4_rsp", {ifc4.rsp1_valid, ifc4.rsp0_valid}, 2'b01);
    chk("lat4_data", ifc4.rsp_data, 16'h4100);
    @(negedge clk);
    chk("lat4_done", {ifc4.done_count, ifc4.disp_value}, {8'd1, 16'h4100});
    // reset during WAIT
    ifc.req0_valid = 1'b1; ifc.req0_a = 16'h4000; ifc.req0_b = 16'h4000; ifc.req0_c = 16'h0000;
    @(negedge clk);
    ifc.req0_valid = 1'b0;
    chk("midwait_busy", ifc.busy, 1);
    reset = 1'b1;
    #1;
    chk("midwait_reset", {ifc.busy, ifc.rsp0_valid, ifc.rsp1_valid}, 0);
    chk("midwait_regs", {ifc.fma_a, ifc.rsp_data, ifc.disp_value, ifc.done_count}, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midwait_quiet", {ifc.busy, ifc.rsp0_valid, ifc.rsp1_valid}, 0);
    end
    // reset during a stalled RESP
    ifc.rsp0_ready = 1'b0;
    ifc.req0_valid = 1'b1; ifc.req0_a = 16'h3F80; ifc.req0_b = 16'h4000; ifc.req0_c = 16'h3F80;
    @(negedge clk);
    ifc.req0_valid = 1'b0;
    @(negedge clk);
    chk("midrsp_valid", ifc.rsp0_valid, 1);
    reset = 1'b1;
    #1;
    chk("midrsp_reset", {ifc.busy, ifc.rsp0_valid, ifc.rsp1_valid}, 0);
    chk("midrsp_regs", {ifc.fma_a, ifc.fma_b, ifc.fma_c, ifc.rsp_data}, 0);
    @(negedge clk);
    ifc.rsp0_ready = 1'b1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrsp_quiet", {ifc.busy, ifc.rsp0_valid, ifc.rsp1_valid, ifc.done_count}, 0);
    end
    // 256 completions: 1.0 * x + 0 passes x through, and the counter wraps
    for (int i = 0; i < 256; i++) begin
      ifc.req0_valid = 1'b1; ifc.req0_a = 16'h3F80; ifc.req0_b = 16'h4000 + 16'(i); ifc.req0_c = 16'h0000;
      @(negedge clk);
      ifc.req0_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("wrap_disp", ifc.disp_value, 16'h4000 + 16'(i));
    end
    chk("wrap_count", ifc.done_count, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
